neuron_accum_ctrl: RTL

//  Sequencer for one shared signed 17-bit adder: computes bias + sum of N_INPUTS

---
 rtl/neuron_accum_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/neuron_accum_ctrl.sv
// Accumulation sequencer for one neuron: bias plus N_INPUTS signed products through a shared
// external adder, with 17-bit saturation of every partial sum and a valid/ready result port.
module neuron_accum_ctrl #(
   parameter int unsigned N_INPUTS = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [16:0] bias,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [16:0] in_data,
   output logic [16:0] add_a,
   output logic [16:0] add_b,
   input  logic [17:0] add_s,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [16:0] out_data,
   output logic        busy,
   output logic        sat_flag
);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_INPUTS - 1);

   state_e           state_q, state_d;
   logic [16:0]      acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   logic        sat_event;
   logic [16:0] sat_val;

   // An 18-bit sum fits in 17 bits only when its top two bits agree.
   always_comb begin
      sat_event = add_s[17] ^ add_s[16];
      if (sat_event) begin
         sat_val = add_s[17] ? 17'h10000 : 17'h0FFFF;
      end else begin
         sat_val = add_s[16:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = bias;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
               acc_d = sat_val;
               cnt_d = cnt_q + CNT_W'(1);
               sat_d = sat_q | sat_event;
               if (cnt_q == LastCnt) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign add_a    = acc_q;
   assign add_b    = in_data;
   assign out_data = acc_q;
   assign sat_flag = sat_q;

endmodule
